card_dealer: RTL and testbench

- Upstream of the card-to-digit converter: deals pseudo-random, never-repeating card indices 0..51 from a virtual 52-card deck.
- Each dealt index goes out on `card` (suit = card/13, rank = card%13) for display conversion and game logic.
- Tracks dealt cards in a 52-bit mask, supports reshuffle, and flags deck exhaustion.

---
 rtl/card_dealer_if.sv | 39 +++
 rtl/card_dealer.sv | 122 ++++++++++++
 tb/tb_card_dealer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// card_dealer_if
// Groups the request, status and dealt-card signals of the card dealer.
//   draw        request one card (driven by the game controller)
//   shuffle     return all 52 cards to the deck (driven by the game controller)
//   card        last dealt index 0..51 (suit = card/13, rank = card%13)
//   card_valid  one-cycle pulse, card is new this cycle
//   busy        a search for an undealt card is in progress
//   deck_empty  no undealt cards remain
//   cards_left  undealt cards remaining, 0..52
// master: the side that requests cards; slave: the dealer itself.
interface card_dealer_if;
  logic       draw;
  logic       shuffle;
  logic [5:0] card;
  logic       card_valid;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;

  modport master (
    output draw,
    output shuffle,
    input  card,
    input  card_valid,
    input  busy,
    input  deck_empty,
    input  cards_left
  );

  modport slave (
    input  draw,
    input  shuffle,
    output card,
    output card_valid,
    output busy,
    output deck_empty,
    output cards_left
  );
endinterface

// File: rtl/card_dealer.sv
// card_dealer
// Deals pseudo-random, never-repeating card indices 0..51 from a virtual
// 52-card deck. A free-running 16-bit Galois LFSR picks a starting slot;
// the dealer then probes forward (wrapping 51 -> 0) one slot per cycle
// until it finds a card that has not been dealt yet.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  card_dealer_if.slave (draw, shuffle in; card, card_valid, busy,
//        deck_empty, cards_left out)
//
// state  | meaning
// IDLE   | waiting for draw; starting slot is taken from the LFSR
// SEARCH | probing one deck slot per cycle for an undealt card
module card_dealer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  card_dealer_if.slave bus
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [5:0]  DECK_SIZE = 6'd52;
  localparam logic [5:0]  LAST_SLOT = 6'd51;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  cand_q, cand_d;
  logic [51:0] dealt_q, dealt_d;
  logic [5:0]  card_q, card_d;
  logic        card_valid_q, card_valid_d;
  logic [5:0]  cards_left_q, cards_left_d;
  logic [5:0]  raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= SEED_EFF;
      cand_q       <= 6'd0;
      dealt_q      <= '0;
      card_q       <= 6'd0;
      card_valid_q <= 1'b0;
      cards_left_q <= DECK_SIZE;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cand_q       <= cand_d;
      dealt_q      <= dealt_d;
      card_q       <= card_d;
      card_valid_q <= card_valid_d;
      cards_left_q <= cards_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    dealt_d      = dealt_q;
    card_d       = card_q;
    card_valid_d = 1'b0;
    cards_left_d = cards_left_q;

    // The LFSR free-runs in every state so the starting slot depends on
    // how long the player waited between draws.
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    raw    = lfsr_q[5:0];

    if (bus.shuffle) begin
      // Shuffle overrides both a new draw and a hit landing this cycle;
      // the last dealt card stays visible on the output.
      dealt_d      = '0;
      cards_left_d = DECK_SIZE;
      state_d      = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.draw && (cards_left_q != 6'd0)) begin
            // Fold 52..63 back into the deck range; slots 0..11 get a
            // slightly higher starting probability, which is acceptable.
            cand_d  = (raw >= DECK_SIZE) ? (raw - DECK_SIZE) : raw;
            state_d = SEARCH;
          end
        end
        SEARCH: begin
          if (dealt_q[cand_q]) begin
            cand_d = (cand_q == LAST_SLOT) ? 6'd0 : (cand_q + 6'd1);
          end else begin
            dealt_d[cand_q] = 1'b1;
            card_d          = cand_q;
            cards_left_d    = cards_left_q - 6'd1;
            card_valid_d    = 1'b1;
            state_d         = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.card       = card_q;
  assign bus.card_valid = card_valid_q;
  assign bus.busy       = (state_q == SEARCH);
  assign bus.cards_left = cards_left_q;
  assign bus.deck_empty = (cards_left_q == 6'd0);

  // Every card is either in the mask or counted as remaining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($countones(dealt_q) + int'(cards_left_q) == 52)
        else $error("card_dealer: dealt mask and cards_left disagree");
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
module tb_card_dealer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  card_dealer_if bus();

  card_dealer #(.LFSR_SEED(16'hACE1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: LFSR per the stated shift rule, plus a plain array
  // of which cards have left the deck.
  logic [15:0] lfsr_m;
  bit          dealt_m [52];
  int          left_m;
  int          seen [52];

  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  function automatic void model_clear();
    for (int i = 0; i < 52; i++) dealt_m[i] = 1'b0;
    left_m = 52;
  endfunction

  function automatic void seen_clear();
    for (int i = 0; i < 52; i++) seen[i] = 0;
  endfunction

  // Number of already-dealt slots met before the first free one.
  function automatic int occupied_before(int start);
    for (int i = 0; i < 52; i++) if (!dealt_m[(start + i) % 52]) return i;
    return -1;
  endfunction

  // Pulses draw for one cycle and watches for the resulting card.
  task automatic do_draw(input bit release_rst, input int max_cyc,
                         output logic [5:0] raw, output logic [5:0] c,
                         output int lat, output int bcnt,
                         output bit got, output bit v_after);
    @(negedge clk);
    if (release_rst) rst = 1'b0;
    raw = lfsr_m[5:0];
    bus.draw = 1'b1;
    lat = 0; bcnt = 0; got = 1'b0; v_after = 1'b0; c = bus.card;
    while (!got && lat < max_cyc) begin
      @(negedge clk);
      bus.draw = 1'b0;
      lat++;
      if (bus.busy) bcnt++;
      if (bus.card_valid) begin
        got = 1'b1;
        c = bus.card;
      end
    end
    bus.draw = 1'b0;
    if (got) begin
      @(negedge clk);
      v_after = bus.card_valid;
    end
  endtask

  task automatic test_reset();
    logic [5:0] raw, c;
    int lat, bcnt;
    bit got, va;
    bus.draw = 1'b0; bus.shuffle = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.card !== 6'd0) begin n_err++; $display("FAIL reset_card got %0d want 0", bus.card); end
    n_cmp++; if (bus.card_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.card_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.deck_empty !== 1'b0) begin n_err++; $display("FAIL reset_empty got %b want 0", bus.deck_empty); end
    n_cmp++; if (bus.cards_left !== 6'd52) begin n_err++; $display("FAIL reset_left got %0d want 52", bus.cards_left); end
    do_draw(1'b1, 60, raw, c, lat, bcnt, got, va);
    n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL first_timeout got %b want 1", got); end
    n_cmp++; if (c !== 6'd33) begin n_err++; $display("FAIL first_card got %0d want 33", c); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL first_latency got %0d want 2", lat); end
    n_cmp++; if (bcnt !== 1) begin n_err++; $display("FAIL first_busy_cycles got %0d want 1", bcnt); end
    n_cmp++; if (va !== 1'b0) begin n_err++; $display("FAIL first_pulse_width got %b want 0", va); end
    n_cmp++; if (bus.cards_left !== 6'd51) begin n_err++; $display("FAIL first_left got %0d want 51", bus.cards_left); end
    dealt_m[33] = 1'b1; left_m = 51;
  endtask

  // Deals n cards with random idle gaps and checks each one against the model.
  task automatic test_deal_sequence(input int n);
    logic [5:0] raw, c;
    int lat, bcnt, start, k, exp_card;
    bit got, va;
    for (int d = 0; d < n; d++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_draw(1'b0, 60, raw, c, lat, bcnt, got, va);
      start = (int'(raw) >= 52) ? int'(raw) - 52 : int'(raw);
      k = occupied_before(start);
      exp_card = (start + k) % 52;
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL deal_timeout draw %0d", d); end
      n_cmp++; if (int'(c) !== exp_card) begin n_err++; $display("FAIL deal_card got %0d want %0d", c, exp_card); end
      n_cmp++; if (lat !== 2 + k) begin n_err++; $display("FAIL deal_latency got %0d want %0d", lat, 2 + k); end
      n_cmp++; if (lat > 53) begin n_err++; $display("FAIL deal_latency_bound got %0d want <=53", lat); end
      n_cmp++; if (bcnt !== 1 + k) begin n_err++; $display("FAIL deal_busy_cycles got %0d want %0d", bcnt, 1 + k); end
      n_cmp++; if (va !== 1'b0) begin n_err++; $display("FAIL deal_pulse_width got %b want 0", va); end
      n_cmp++; if (int'(bus.cards_left) !== left_m - 1) begin n_err++; $display("FAIL deal_left got %0d want %0d", bus.cards_left, left_m - 1); end
      n_cmp++; if (bus.deck_empty !== (left_m == 1)) begin n_err++; $display("FAIL deal_empty got %b want %b", bus.deck_empty, left_m == 1); end
      if (exp_card >= 0) dealt_m[exp_card] = 1'b1;
      left_m--;
      if (int'(c) < 52) seen[c]++;
    end
  endtask

  task automatic test_full_deck();
    int bad;
    seen_clear();
    seen[33] = 1;
    test_deal_sequence(51);
    bad = 0;
    for (int i = 0; i < 52; i++) if (seen[i] != 1) bad++;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL full_perm got %0d bad slots want 0", bad); end
    n_cmp++; if (bus.deck_empty !== 1'b1) begin n_err++; $display("FAIL full_empty got %b want 1", bus.deck_empty); end
    n_cmp++; if (bus.cards_left !== 6'd0) begin n_err++; $display("FAIL full_left got %0d want 0", bus.cards_left); end
  endtask

  task automatic test_empty_deck();
    logic [5:0] raw, c, c0;
    int lat, bcnt;
    bit got, va;
    c0 = bus.card;
    for (int i = 0; i < 5; i++) begin
      do_draw(1'b0, 8, raw, c, lat, bcnt, got, va);
      n_cmp++; if (got !== 1'b0) begin n_err++; $display("FAIL empty_valid got %b want 0", got); end
      n_cmp++; if (bcnt !== 0) begin n_err++; $display("FAIL empty_busy got %0d want 0", bcnt); end
      n_cmp++; if (bus.card !== c0) begin n_err++; $display("FAIL empty_card got %0d want %0d", bus.card, c0); end
    end
  endtask

  task automatic test_shuffle();
    int bad;
    @(negedge clk); bus.shuffle = 1'b1;
    @(negedge clk); bus.shuffle = 1'b0;
    model_clear();
    test_deal_sequence(10);
    @(negedge clk); bus.shuffle = 1'b1;
    @(negedge clk); bus.shuffle = 1'b0;
    n_cmp++; if (bus.cards_left !== 6'd52) begin n_err++; $display("FAIL shuffle_left got %0d want 52", bus.cards_left); end
    n_cmp++; if (bus.deck_empty !== 1'b0) begin n_err++; $display("FAIL shuffle_empty got %b want 0", bus.deck_empty); end
    model_clear();
    seen_clear();
    test_deal_sequence(52);
    bad = 0;
    for (int i = 0; i < 52; i++) if (seen[i] != 1) bad++;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL shuffle_perm got %0d bad slots want 0", bad); end
  endtask

  task automatic test_abort();
    int vcnt, bcnt;
    @(negedge clk); bus.shuffle = 1'b1;
    @(negedge clk); bus.shuffle = 1'b0;
    model_clear();
    test_deal_sequence(3);
    // Shuffle during SEARCH.
    @(negedge clk); bus.draw = 1'b1;
    @(negedge clk); bus.draw = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy got %b want 1", bus.busy); end
    bus.shuffle = 1'b1;
    vcnt = 0; bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); bus.shuffle = 1'b0;
      if (bus.card_valid) vcnt++;
      if (bus.busy) bcnt++;
    end
    model_clear();
    n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL abort_valid got %0d pulses want 0", vcnt); end
    n_cmp++; if (bcnt !== 0) begin n_err++; $display("FAIL abort_idle got %0d busy cycles want 0", bcnt); end
    n_cmp++; if (bus.cards_left !== 6'd52) begin n_err++; $display("FAIL abort_left got %0d want 52", bus.cards_left); end
    // Shuffle and draw together.
    @(negedge clk); bus.draw = 1'b1; bus.shuffle = 1'b1;
    vcnt = 0; bcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); bus.draw = 1'b0; bus.shuffle = 1'b0;
      if (bus.card_valid) vcnt++;
      if (bus.busy) bcnt++;
    end
    n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL conflict_valid got %0d pulses want 0", vcnt); end
    n_cmp++; if (bcnt !== 0) begin n_err++; $display("FAIL conflict_busy got %0d want 0", bcnt); end
    n_cmp++; if (bus.cards_left !== 6'd52) begin n_err++; $display("FAIL conflict_left got %0d want 52", bus.cards_left); end
  endtask

  task automatic test_mid_reset();
    logic [5:0] raw, c;
    int lat, bcnt;
    bit got, va;
    test_deal_sequence(2);
    @(negedge clk); bus.draw = 1'b1;
    @(negedge clk); bus.draw = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b want 1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    n_cmp++; if (bus.card !== 6'd0) begin n_err++; $display("FAIL midrst_card got %0d want 0", bus.card); end
    n_cmp++; if (bus.card_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", bus.card_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.deck_empty !== 1'b0) begin n_err++; $display("FAIL midrst_empty got %b want 0", bus.deck_empty); end
    n_cmp++; if (bus.cards_left !== 6'd52) begin n_err++; $display("FAIL midrst_left got %0d want 52", bus.cards_left); end
    // A seeded LFSR makes the first card after release 33 again.
    do_draw(1'b1, 60, raw, c, lat, bcnt, got, va);
    n_cmp++; if (c !== 6'd33) begin n_err++; $display("FAIL midrst_reseed_card got %0d want 33", c); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL midrst_reseed_latency got %0d want 2", lat); end
  endtask

  initial begin
    bus.draw = 1'b0;
    bus.shuffle = 1'b0;
    test_reset();
    test_full_deck();
    test_empty_deck();
    test_shuffle();
    test_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
